// File: rtl/xbar_switch_allocator.sv
// xbar_switch_allocator: wormhole switch allocator for an IN_N x OUT_M crossbar.
// Each output has a round-robin arbiter. A winning input keeps the output from
// its head flit to its tail flit. Outputs allocate and transfer independently.
// Optional build macro XBAR_ALLOC_STATS_EN adds per-output tail-transfer
// counters on port pkt_cnt_o.
module xbar_switch_allocator #(
    parameter int IN_N  = 5,
    parameter int OUT_M = 5
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [IN_N-1:0]                valid_i,
    input  logic [IN_N-1:0][OUT_M-1:0]     dest_i,
    input  logic [IN_N-1:0]                tail_i,
    input  logic [OUT_M-1:0]               ready_i,
    output logic [OUT_M-1:0][IN_N-1:0]     sel_o,
    output logic [OUT_M-1:0]               valid_o,
    output logic [IN_N-1:0]                pop_o
`ifdef XBAR_ALLOC_STATS_EN
    ,
    output logic [OUT_M-1:0][15:0]         pkt_cnt_o
`endif
);

    localparam int IW = (IN_N > 1) ? $clog2(IN_N) : 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e          state_r     [OUT_M];
    state_e          state_nx_s  [OUT_M];
    logic [IW-1:0]   owner_r     [OUT_M];
    logic [IW-1:0]   owner_nx_s  [OUT_M];
    logic [IW-1:0]   ptr_r       [OUT_M];
    logic [IW-1:0]   ptr_nx_s    [OUT_M];
    logic [IN_N-1:0] req_s       [OUT_M];
    logic [IN_N-1:0] own_oh_s    [OUT_M];
    logic [IN_N-1:0] hi_req_s    [OUT_M];
    logic [IW-1:0]   grant_idx_s [OUT_M];
    logic [OUT_M-1:0] grant_vld_s;
    logic [OUT_M-1:0] xfer_s;
    logic [OUT_M-1:0] xfer_tail_s;

    // Index of the lowest set bit of vec (0 when vec is empty).
    function automatic logic [IW-1:0] lowest_set(input logic [IN_N-1:0] vec);
        logic [IW-1:0] idx;
        idx = {IW{1'b0}};
        for (int i = IN_N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Per-output request vectors and one-hot decode of the current owner.
    always_comb begin
        for (int o = 0; o < OUT_M; o++) begin
            for (int i = 0; i < IN_N; i++) begin
                req_s[o][i]    = valid_i[i] & dest_i[i][o];
                own_oh_s[o][i] = (owner_r[o] == IW'(i));
            end
        end
    end

    // Round-robin pick: first requester strictly after ptr, else wrap to the lowest.
    always_comb begin
        for (int o = 0; o < OUT_M; o++) begin
            for (int i = 0; i < IN_N; i++) begin
                hi_req_s[o][i] = req_s[o][i] & (IW'(i) > ptr_r[o]);
            end
            grant_vld_s[o] = |req_s[o];
            grant_idx_s[o] = (|hi_req_s[o]) ? lowest_set(hi_req_s[o])
                                            : lowest_set(req_s[o]);
        end
    end

    // State register: IDLE/LOCKED, owner and round-robin pointer per output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int o = 0; o < OUT_M; o++) begin
                state_r[o] <= ST_IDLE;
                owner_r[o] <= {IW{1'b0}};
                ptr_r[o]   <= IW'(IN_N - 1);
            end
        end else begin
            for (int o = 0; o < OUT_M; o++) begin
                state_r[o] <= state_nx_s[o];
                owner_r[o] <= owner_nx_s[o];
                ptr_r[o]   <= ptr_nx_s[o];
            end
        end
    end

    // Next state: lock on a grant, release after the tail flit has moved.
    always_comb begin
        for (int o = 0; o < OUT_M; o++) begin
            state_nx_s[o] = state_r[o];
            owner_nx_s[o] = owner_r[o];
            ptr_nx_s[o]   = ptr_r[o];
            case (state_r[o])
                ST_IDLE: begin
                    if (grant_vld_s[o]) begin
                        state_nx_s[o] = ST_LOCKED;
                        owner_nx_s[o] = grant_idx_s[o];
                    end else begin
                        state_nx_s[o] = ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (xfer_tail_s[o]) begin
                        state_nx_s[o] = ST_IDLE;
                        ptr_nx_s[o]   = owner_r[o];
                    end else begin
                        state_nx_s[o] = ST_LOCKED;
                    end
                end
                default: begin
                    state_nx_s[o] = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs: select follows the registered owner; transfer needs owner flit and ready.
    always_comb begin
        pop_o = {IN_N{1'b0}};
        for (int o = 0; o < OUT_M; o++) begin
            sel_o[o]       = {IN_N{1'b0}};
            valid_o[o]     = 1'b0;
            xfer_s[o]      = 1'b0;
            xfer_tail_s[o] = 1'b0;
            case (state_r[o])
                ST_IDLE: begin
                    sel_o[o] = {IN_N{1'b0}};
                end
                ST_LOCKED: begin
                    sel_o[o]       = own_oh_s[o];
                    xfer_s[o]      = (|(own_oh_s[o] & req_s[o])) & ready_i[o];
                    xfer_tail_s[o] = xfer_s[o] & (|(own_oh_s[o] & tail_i));
                    valid_o[o]     = xfer_s[o];
                    pop_o          = pop_o | (own_oh_s[o] & {IN_N{xfer_s[o]}});
                end
                default: begin
                    sel_o[o] = {IN_N{1'b0}};
                end
            endcase
        end
    end

`ifdef XBAR_ALLOC_STATS_EN
    // Packet counters: one count per tail transfer, wrapping naturally at 16 bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int o = 0; o < OUT_M; o++) begin
                pkt_cnt_o[o] <= {16{1'b0}};
            end
        end else begin
            for (int o = 0; o < OUT_M; o++) begin
                if (xfer_tail_s[o]) begin
                    pkt_cnt_o[o] <= pkt_cnt_o[o] + 16'd1;
                end else begin
                    pkt_cnt_o[o] <= pkt_cnt_o[o];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_xbar_switch_allocator.sv
// Directed testbench for xbar_switch_allocator (5x5). Each stimulus cycle pushes
// its hand-computed expected sel/valid/pop into a scoreboard queue; a separate
// monitor pops and compares on the falling edge.
module tb_xbar_switch_allocator;

    localparam logic [4:0] ALL = 5'b11111;

    logic             clk;
    logic             rst;
    logic [4:0]       valid;
    logic [4:0][4:0]  dest;
    logic [4:0]       tail;
    logic [4:0]       ready;
    logic [4:0][4:0]  sel;
    logic [4:0]       vld_o;
    logic [4:0]       pop;
`ifdef XBAR_ALLOC_STATS_EN
    logic [4:0][15:0] pkt_cnt;
`endif

    logic [4:0][4:0]  dst;

    typedef struct {
        string           nm;
        logic [4:0][4:0] sel;
        logic [4:0]      vld;
        logic [4:0]      pop;
        int              cnt2;
    } exp_t;

    exp_t sbq[$];
    int   n_vec;
    int   n_err;

    xbar_switch_allocator #(.IN_N(5), .OUT_M(5)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .valid_i   (valid),
        .dest_i    (dest),
        .tail_i    (tail),
        .ready_i   (ready),
        .sel_o     (sel),
        .valid_o   (vld_o),
        .pop_o     (pop)
`ifdef XBAR_ALLOC_STATS_EN
        ,
        .pkt_cnt_o (pkt_cnt)
`endif
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-hot select for output o driven by input one-hot oh.
    function automatic logic [24:0] sl(input int o, input logic [4:0] oh);
        logic [24:0] r;
        r = 25'd0;
        r[o*5 +: 5] = oh;
        return r;
    endfunction

    // Drive one cycle of stimulus and queue its expected outputs.
    task automatic step(input logic r, input logic [4:0] v, input logic [4:0] t,
                        input logic [4:0] rdy, input logic [24:0] es,
                        input logic [4:0] ev, input logic [4:0] ep,
                        input int c2, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst   = r;
        valid = v;
        tail  = t;
        ready = rdy;
        dest  = dst;
        e.nm   = nm;
        e.sel  = es;
        e.vld  = ev;
        e.pop  = ep;
        e.cnt2 = c2;
        sbq.push_back(e);
    endtask

    // Monitor: compare queued expectations against the DUT on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                n_vec++;
                if (sel !== e.sel || vld_o !== e.vld || pop !== e.pop) begin
                    n_err++;
                    $display("FAIL %s: got sel=%h valid=%b pop=%b, expected sel=%h valid=%b pop=%b",
                             e.nm, sel, vld_o, pop, e.sel, e.vld, e.pop);
                end
`ifdef XBAR_ALLOC_STATS_EN
                if (e.cnt2 >= 0) begin
                    n_vec++;
                    if (pkt_cnt[2] !== 16'(e.cnt2)) begin
                        n_err++;
                        $display("FAIL %s_cnt: got pkt_cnt[2]=%0d, expected %0d",
                                 e.nm, pkt_cnt[2], e.cnt2);
                    end
                end
`endif
            end
            for (int i = 0; i < 5; i++) begin
                if (!$onehot0(dest[i])) begin
                    n_err++;
                    $display("FAIL dest_onehot: input %0d dest=%b, expected one-hot or zero",
                             i, dest[i]);
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        logic [4:0] oh;
        int         owners [3];
        n_vec  = 0;
        n_err  = 0;
        rst    = 1'b1;
        valid  = 5'd0;
        tail   = 5'd0;
        ready  = ALL;
        dst    = 25'd0;
        dest   = 25'd0;
        owners = '{0, 1, 4};

        // Reset with no traffic.
        step(1'b1, 5'd0, 5'd0, ALL, 25'd0, 5'd0, 5'd0, -1, "rst_a");
        step(1'b1, 5'd0, 5'd0, ALL, 25'd0, 5'd0, 5'd0, 0,  "rst_b");

        // Basic 3-flit packet, input 3 -> output 2.
        dst[3] = 5'b00100;
        step(1'b0, 5'b01000, 5'd0,     ALL, 25'd0,             5'd0,     5'd0,     -1, "basic_alloc");
        step(1'b0, 5'b01000, 5'd0,     ALL, sl(2, 5'b01000),   5'b00100, 5'b01000, -1, "basic_f1");
        step(1'b0, 5'b01000, 5'd0,     ALL, sl(2, 5'b01000),   5'b00100, 5'b01000, -1, "basic_f2");
        step(1'b0, 5'b01000, 5'b01000, ALL, sl(2, 5'b01000),   5'b00100, 5'b01000, -1, "basic_tail");
        step(1'b0, 5'd0,     5'd0,     ALL, 25'd0,             5'd0,     5'd0,     -1, "basic_idle");

        // Round robin on output 0 among inputs 0, 1, 4 with single-flit packets.
        dst[0] = 5'b00001;
        dst[1] = 5'b00001;
        dst[4] = 5'b00001;
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int k = 0; k < 3; k++) begin
                oh = 5'b00001 << owners[k];
                step(1'b0, 5'b10011, 5'b10011, ALL, 25'd0,     5'd0,     5'd0, -1, "rr_alloc");
                step(1'b0, 5'b10011, 5'b10011, ALL, sl(0, oh), 5'b00001, oh,   -1, "rr_grant");
            end
        end
        step(1'b0, 5'd0, 5'd0, ALL, 25'd0, 5'd0, 5'd0, -1, "rr_idle");

        // Lock and backpressure on output 1: input 1 owns, input 0 waits.
        dst[0] = 5'b00010;
        dst[1] = 5'b00010;
        step(1'b0, 5'b00010, 5'd0,     ALL,      25'd0,           5'd0,     5'd0,     -1, "lock_alloc");
        step(1'b0, 5'b00010, 5'd0,     ALL,      sl(1, 5'b00010), 5'b00010, 5'b00010, -1, "lock_head");
        step(1'b0, 5'b00011, 5'd0,     5'b11101, sl(1, 5'b00010), 5'd0,     5'd0,     -1, "lock_stall1");
        step(1'b0, 5'b00011, 5'd0,     5'b11101, sl(1, 5'b00010), 5'd0,     5'd0,     -1, "lock_stall2");
        step(1'b0, 5'b00011, 5'd0,     5'b11101, sl(1, 5'b00010), 5'd0,     5'd0,     -1, "lock_stall3");
        step(1'b0, 5'b00001, 5'd0,     ALL,      sl(1, 5'b00010), 5'd0,     5'd0,     -1, "lock_bubble");
        step(1'b0, 5'b00011, 5'b00010, ALL,      sl(1, 5'b00010), 5'b00010, 5'b00010, -1, "lock_tail");
        step(1'b0, 5'b00011, 5'b00001, ALL,      25'd0,           5'd0,     5'd0,     -1, "lock_realloc");
        step(1'b0, 5'b00011, 5'b00001, ALL,      sl(1, 5'b00001), 5'b00010, 5'b00001, -1, "lock_rr_next");
        step(1'b0, 5'b00010, 5'b00010, ALL,      25'd0,           5'd0,     5'd0,     -1, "lock_alloc2");
        step(1'b0, 5'b00010, 5'b00010, ALL,      sl(1, 5'b00010), 5'b00010, 5'b00010, -1, "lock_single");
        step(1'b0, 5'd0,     5'd0,     ALL,      25'd0,           5'd0,     5'd0,     -1, "lock_idle");

        // Parallel: 0->4, 2->3, 4->0.
        dst[0] = 5'b10000;
        dst[2] = 5'b01000;
        dst[4] = 5'b00001;
        step(1'b0, 5'b10101, 5'd0, ALL, 25'd0, 5'd0, 5'd0, -1, "par_alloc");
        step(1'b0, 5'b10101, 5'd0, ALL,
             sl(4, 5'b00001) | sl(3, 5'b00100) | sl(0, 5'b10000), 5'b11001, 5'b10101, -1, "par_f1");
        step(1'b0, 5'b10101, 5'b10101, ALL,
             sl(4, 5'b00001) | sl(3, 5'b00100) | sl(0, 5'b10000), 5'b11001, 5'b10101, -1, "par_tail");
        step(1'b0, 5'd0, 5'd0, ALL, 25'd0, 5'd0, 5'd0, -1, "par_idle");

        // Move output 2 pointer to input 1 so that, without a reset, input 3 would win next.
        dst[0] = 5'b00100;
        dst[1] = 5'b00100;
        step(1'b0, 5'b00010, 5'b00010, ALL, 25'd0,           5'd0,     5'd0,     -1, "pre_alloc");
        step(1'b0, 5'b00010, 5'b00010, ALL, sl(2, 5'b00010), 5'b00100, 5'b00010, -1, "pre_single");

        // Reset while output 2 is locked to input 3.
        step(1'b0, 5'b01000, 5'd0,     ALL, 25'd0,           5'd0,     5'd0,     -1, "mid_alloc");
        step(1'b0, 5'b01000, 5'd0,     ALL, sl(2, 5'b01000), 5'b00100, 5'b01000, -1, "mid_head");
        step(1'b1, 5'b01000, 5'd0,     ALL, sl(2, 5'b01000), 5'b00100, 5'b01000, 2,  "mid_rst_cycle");
        step(1'b0, 5'b01001, 5'd0,     ALL, 25'd0,           5'd0,     5'd0,     0,  "mid_after_rst");
        step(1'b0, 5'b01001, 5'd0,     ALL, sl(2, 5'b00001), 5'b00100, 5'b00001, -1, "mid_rr_reset");
        step(1'b0, 5'b01001, 5'b00001, ALL, sl(2, 5'b00001), 5'b00100, 5'b00001, -1, "mid_tail");
        step(1'b0, 5'd0,     5'd0,     ALL, 25'd0,           5'd0,     5'd0,     1,  "mid_idle");

        @(posedge clk);
        @(posedge clk);
        n_vec++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
